// File: rtl/booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath: clear, load, ITERATIONS x (eval, [add|sub], shift), done.
// Multiply takes 3 + 2*ITERATIONS + (arithmetic iterations) cycles to done; no backpressure. Optional abort via BOOTH_CTRL_ABORT_EN.
module booth_ctrl #(
  parameter int ITERATIONS = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] qbits,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       dp_clear,
  output logic       load,
  output logic       add_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic       count_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_EVAL  = 3'd3,
    S_ADD   = 3'd4,
    S_SUB   = 3'd5,
    S_SHIFT = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter;
  logic             aborting;
  logic             aborting_nxt;

  always_comb begin
    state_nxt    = state;
    aborting_nxt = aborting;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        // An aborted run reuses CLEAR to scrub the datapath, then parks.
        state_nxt    = aborting ? S_IDLE : S_LOAD;
        aborting_nxt = 1'b0;
      end
      S_LOAD:  state_nxt = S_EVAL;
      S_EVAL: begin
        case (qbits)
          2'b10:   state_nxt = S_SUB;
          2'b01:   state_nxt = S_ADD;
          default: state_nxt = S_SHIFT;
        endcase
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SUB:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = (iter == LAST_ITER) ? S_DONE : S_EVAL;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
`ifdef BOOTH_CTRL_ABORT_EN
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      if (state == S_CLEAR) begin
        state_nxt    = S_IDLE;
        aborting_nxt = 1'b0;
      end else begin
        state_nxt    = S_CLEAR;
        aborting_nxt = 1'b1;
      end
    end
`endif
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      aborting <= 1'b0;
      iter     <= '0;
      dp_clear <= 1'b0;
      load     <= 1'b0;
      add_en   <= 1'b0;
      sub_en   <= 1'b0;
      shift_en <= 1'b0;
      count_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      aborting <= aborting_nxt;
      if (state == S_CLEAR)
        iter <= '0;
      else if (state == S_SHIFT)
        iter <= iter + CNT_W'(1);
      dp_clear <= (state_nxt == S_CLEAR);
      load     <= (state_nxt == S_LOAD);
      add_en   <= (state_nxt == S_ADD);
      sub_en   <= (state_nxt == S_SUB);
      shift_en <= (state_nxt == S_SHIFT);
      count_en <= (state_nxt == S_SHIFT);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
    end
  end

  a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({dp_clear, load, add_en, sub_en, shift_en}));

  a_count_with_shift: assert property (@(posedge clk) disable iff (reset)
    count_en |-> shift_en);

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural Booth datapath drives qbits; strobe traces derived from multiplier bit pairs.
module tb_booth_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] qbits;
  logic       dp_clear, load, add_en, sub_en, shift_en, count_en, busy, done;
`ifdef BOOTH_CTRL_ABORT_EN
  logic       abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_ctrl #(.ITERATIONS(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .qbits    (qbits),
`ifdef BOOTH_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .dp_clear (dp_clear),
    .load     (load),
    .add_en   (add_en),
    .sub_en   (sub_en),
    .shift_en (shift_en),
    .count_en (count_en),
    .busy     (busy),
    .done     (done)
  );

  // Behavioural datapath: {A, Q, Q-1} with multiplicand, driven by the DUT strobes.
  logic [7:0] a_r = 8'h00;
  logic [7:0] q_r = 8'h00;
  logic       q1  = 1'b0;
  logic [7:0] mult_op  = 8'h00;
  logic [7:0] mcand_op = 8'h00;

  always @(posedge clk) begin
    if (reset || dp_clear) begin
      a_r <= 8'h00; q_r <= 8'h00; q1 <= 1'b0;
    end else if (load) begin
      a_r <= 8'h00; q_r <= mult_op; q1 <= 1'b0;
    end else if (add_en) begin
      a_r <= a_r + mcand_op;
    end else if (sub_en) begin
      a_r <= a_r - mcand_op;
    end else if (shift_en) begin
      {a_r, q_r, q1} <= {a_r[7], a_r, q_r[7:1], q_r[0]};
    end
  end

  assign qbits = {q_r[0], q1};

  // Bit order: dp_clear load add sub shift count busy done
  function automatic logic [7:0] obs();
    return {dp_clear, load, add_en, sub_en, shift_en, count_en, busy, done};
  endfunction

  localparam logic [7:0] V_CLEAR = 8'b1000_0010;
  localparam logic [7:0] V_LOAD  = 8'b0100_0010;
  localparam logic [7:0] V_EVAL  = 8'b0000_0010;
  localparam logic [7:0] V_ADD   = 8'b0010_0010;
  localparam logic [7:0] V_SUB   = 8'b0001_0010;
  localparam logic [7:0] V_SHIFT = 8'b0000_1110;
  localparam logic [7:0] V_DONE  = 8'b0000_0011;
  localparam logic [7:0] V_IDLE  = 8'b0000_0000;

  task automatic run_mult(input logic [7:0] m, input logic [7:0] mc, input string name,
                          input int p1, input int p2, input bit hold);
    logic [7:0]        exp_q[$];
    logic [8:0]        mx;
    int                arith;
    int                done_cyc;
    int                shifts;
    int                subs_first;
    logic signed [15:0] prod_exp;
    logic signed [15:0] prod_got;
    logic [7:0]        o;
    exp_q = {};
    arith = 0;
    mx = {m, 1'b0};
    exp_q.push_back(V_CLEAR);
    exp_q.push_back(V_LOAD);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(V_EVAL);
      if (mx[i+1 -: 2] == 2'b10) begin exp_q.push_back(V_SUB); arith++; end
      else if (mx[i+1 -: 2] == 2'b01) begin exp_q.push_back(V_ADD); arith++; end
      exp_q.push_back(V_SHIFT);
    end
    exp_q.push_back(V_DONE);
    exp_q.push_back(V_IDLE);
    prod_exp = $signed(m) * $signed(mc);
    mult_op = m;
    mcand_op = mc;
    done_cyc = -1;
    shifts = 0;
    subs_first = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      o = obs();
      if (o[0] && done_cyc < 0) done_cyc = k;
      if (o[3]) shifts++;
      checks++;
      if (o !== exp_q[k-1]) begin
        errors++;
        $display("FAIL %s cycle %0d strobes: got %b expected %b", name, k, o, exp_q[k-1]);
      end
      start = (hold || k == p1 || k == p2) ? 1'b1 : 1'b0;
    end
    checks++;
    if (done_cyc !== 19 + arith) begin
      errors++;
      $display("FAIL %s done cycle: got %0d expected %0d", name, done_cyc, 19 + arith);
    end
    checks++;
    if (shifts !== 8) begin
      errors++;
      $display("FAIL %s shift count: got %0d expected 8", name, shifts);
    end
    prod_got = $signed({a_r, q_r});
    checks++;
    if (prod_got !== prod_exp) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", name, prod_got, prod_exp);
    end
    if (hold) begin
      // IDLE sat one cycle after done; the held start relaunches right after it.
      @(negedge clk);
      checks++;
      if (obs() !== V_CLEAR) begin
        errors++;
        $display("FAIL %s held start relaunch: got %b expected %b", name, obs(), V_CLEAR);
      end
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs(), V_IDLE);
    end
    mult_op = 8'h5A;
    mcand_op = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== V_IDLE) begin
        errors++;
        $display("FAIL reset_mid_op[%0d]: got %b expected %b", i, obs(), V_IDLE);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs(), V_IDLE);
    end
    run_mult(8'h5A, 8'h11, "after_reset", -1, -1, 1'b0);
  endtask

  task automatic test_mult3();
    run_mult(8'h03, 8'h05, "mult3", -1, -1, 1'b0);
  endtask

  task automatic test_zero();
    run_mult(8'h00, 8'($urandom_range(0, 255)), "mult0", -1, -1, 1'b0);
  endtask

  task automatic test_alternating();
    run_mult(8'h55, 8'hFD, "mult55", -1, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_mult(8'h03, 8'h07, "start_pulses", 5, 18, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_mult(8'hC6, 8'h2B, "start_held", -1, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random", -1, -1, 1'b0);
  endtask

`ifdef BOOTH_CTRL_ABORT_EN
  task automatic test_abort();
    int done_seen;
    logic [7:0] o;
    done_seen = 0;
    mult_op = 8'h55;
    mcand_op = 8'h13;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      o = obs();
      if (o[0]) done_seen++;
      if (k == 11) begin
        checks++;
        if (o !== V_CLEAR) begin
          errors++;
          $display("FAIL abort_clear: got %b expected %b", o, V_CLEAR);
        end
      end
      if (k == 12) begin
        checks++;
        if (o !== V_IDLE) begin
          errors++;
          $display("FAIL abort_idle: got %b expected %b", o, V_IDLE);
        end
      end
      start = 1'b0;
      abort = (k == 10) ? 1'b1 : 1'b0;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef BOOTH_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult3();
    test_zero();
    test_alternating();
    test_start_ignored();
    test_back_to_back();
    test_random();
`ifdef BOOTH_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
